ycbcr444_to_422: RTL and testbench

Chroma subsampler that converts the YCbCr 4:4:4 pixel stream from the RGB-to-YCbCr converter into 4:2:2. It pairs horizontally adjacent pixels within each active run and averages their Cb and Cr. It emits one luma sample per pixel, with chroma alternating Cb/Cr. It sits directly downstream of the colour converter and consumes its y/cb/cr/de/hs/vs/bypass outputs unchanged.

---
 rtl/video_pkg.sv | 21 ++
 rtl/video_sync_delay.sv | 30 +++
 rtl/ycbcr444_to_422.sv | 105 ++++++++++
 tb/tb_ycbcr444_to_422.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared video definitions: chroma selector encoding, default widths and a
// round-half-up average reused by the chroma subsampler and future scalers.
package video_pkg;

    localparam int DEFAULT_PIXEL_WIDTH  = 8;
    localparam int DEFAULT_BYPASS_WIDTH = 8;
    localparam int AVG_MAX_WIDTH        = 16;

    typedef enum logic {C_CB = 1'b0, C_CR = 1'b1} chroma_sel_t;

    // Callers zero-extend narrower components; the extra sum bit prevents overflow.
    function automatic logic [AVG_MAX_WIDTH-1:0] avg_round_up(
        input logic [AVG_MAX_WIDTH-1:0] a,
        input logic [AVG_MAX_WIDTH-1:0] b
    );
        logic [AVG_MAX_WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b} + {{AVG_MAX_WIDTH{1'b0}}, 1'b1};
        return sum[AVG_MAX_WIDTH:1];
    endfunction

endpackage

// File: rtl/video_sync_delay.sv
// Fixed-depth shift register for sync and sideband signals that travel
// alongside the video datapath.
module video_sync_delay #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] pipe [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign q = pipe[DEPTH-1];

endmodule

// File: rtl/ycbcr444_to_422.sv
// YCbCr 4:4:4 to 4:2:2 chroma subsampler: pairs adjacent pixels of each active
// run, emits Cb on the even pixel and Cr on the odd one, two-cycle latency.
module ycbcr444_to_422
    import video_pkg::*;
#(
    parameter int PIXEL_WIDTH  = DEFAULT_PIXEL_WIDTH,
    parameter int BYPASS_WIDTH = DEFAULT_BYPASS_WIDTH,
    parameter bit AVERAGE      = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [PIXEL_WIDTH-1:0]  y_i,
    input  logic [PIXEL_WIDTH-1:0]  cb_i,
    input  logic [PIXEL_WIDTH-1:0]  cr_i,
    input  logic                    de_i,
    input  logic                    hs_i,
    input  logic                    vs_i,
    input  logic [BYPASS_WIDTH-1:0] bypass_i,
    output logic [PIXEL_WIDTH-1:0]  y_o,
    output logic [PIXEL_WIDTH-1:0]  c_o,
    output logic                    c_sel_o,
    output logic                    de_o,
    output logic                    hs_o,
    output logic                    vs_o,
    output logic [BYPASS_WIDTH-1:0] bypass_o
);

    logic                   phase;
    logic [PIXEL_WIDTH-1:0] s1_y;
    logic [PIXEL_WIDTH-1:0] s1_cb;
    logic [PIXEL_WIDTH-1:0] s1_cr;
    logic                   s1_de;
    logic                   s1_phase;
    logic [PIXEL_WIDTH-1:0] cr_hold;
    logic [PIXEL_WIDTH-1:0] cb_pair;
    logic [PIXEL_WIDTH-1:0] cr_pair;

    always_comb begin
        cb_pair = s1_cb;
        cr_pair = s1_cr;
        if (AVERAGE) begin
            cb_pair = PIXEL_WIDTH'(avg_round_up(AVG_MAX_WIDTH'(s1_cb), AVG_MAX_WIDTH'(cb_i)));
            cr_pair = PIXEL_WIDTH'(avg_round_up(AVG_MAX_WIDTH'(s1_cr), AVG_MAX_WIDTH'(cr_i)));
        end
    end

    // An even pixel in s1 is paired with whatever is at the input only if de_i is high;
    // the Cr half of the pair is parked in cr_hold for the following odd pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase    <= 1'b0;
            s1_y     <= '0;
            s1_cb    <= '0;
            s1_cr    <= '0;
            s1_de    <= 1'b0;
            s1_phase <= 1'b0;
            cr_hold  <= '0;
            y_o      <= '0;
            c_o      <= '0;
            c_sel_o  <= C_CB;
            de_o     <= 1'b0;
        end else begin
            phase    <= de_i ? ~phase : 1'b0;
            s1_y     <= y_i;
            s1_cb    <= cb_i;
            s1_cr    <= cr_i;
            s1_de    <= de_i;
            s1_phase <= de_i & phase;
            de_o     <= s1_de;
            if (!s1_de) begin
                y_o     <= '0;
                c_o     <= '0;
                c_sel_o <= C_CB;
            end else if (s1_phase) begin
                y_o     <= s1_y;
                c_o     <= cr_hold;
                c_sel_o <= C_CR;
            end else if (de_i) begin
                y_o     <= s1_y;
                c_o     <= cb_pair;
                c_sel_o <= C_CB;
                cr_hold <= cr_pair;
            end else begin
                y_o     <= s1_y;
                c_o     <= s1_cb;
                c_sel_o <= C_CB;
            end
        end
    end

    logic [BYPASS_WIDTH+1:0] sync_q;

    video_sync_delay #(
        .DEPTH(2),
        .WIDTH(BYPASS_WIDTH + 2)
    ) u_sync_delay (
        .clk  (clk),
        .rst_n(rst_n),
        .d    ({hs_i, vs_i, bypass_i}),
        .q    (sync_q)
    );

    assign {hs_o, vs_o, bypass_o} = sync_q;

endmodule

// File: tb/tb_ycbcr444_to_422.sv
// Self-checking bench for ycbcr444_to_422: a history-based reference model
// (run position -> Cb/Cr pairing) checks an averaging and a non-averaging DUT.
module tb_ycbcr444_to_422;

    logic       clk;
    logic       rst_n;
    logic [7:0] y_i, cb_i, cr_i, bypass_i;
    logic       de_i, hs_i, vs_i;

    logic [7:0] y_o, c_o, bypass_o;
    logic       c_sel_o, de_o, hs_o, vs_o;
    logic [7:0] y_n, c_n, bypass_n;
    logic       c_sel_n, de_n, hs_n, vs_n;

    logic [27:0] got_a, got_n;
    assign got_a = {y_o, c_o, c_sel_o, de_o, hs_o, vs_o, bypass_o};
    assign got_n = {y_n, c_n, c_sel_n, de_n, hs_n, vs_n, bypass_n};

    int checks = 0;
    int errors = 0;

    // Input history indexed by the clock edge that captures each sample.
    localparam int HIST = 4096;
    logic [7:0] y_h [HIST];
    logic [7:0] cb_h [HIST];
    logic [7:0] cr_h [HIST];
    logic [7:0] byp_h [HIST];
    logic       de_h [HIST];
    logic       hs_h [HIST];
    logic       vs_h [HIST];
    int         run_pos [HIST];
    int         edge_cnt = 0;
    int         first_valid = 1 << 30;

    ycbcr444_to_422 #(.PIXEL_WIDTH(8), .BYPASS_WIDTH(8), .AVERAGE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .y_i(y_i), .cb_i(cb_i), .cr_i(cr_i),
        .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i), .bypass_i(bypass_i),
        .y_o(y_o), .c_o(c_o), .c_sel_o(c_sel_o), .de_o(de_o),
        .hs_o(hs_o), .vs_o(vs_o), .bypass_o(bypass_o)
    );

    ycbcr444_to_422 #(.PIXEL_WIDTH(8), .BYPASS_WIDTH(8), .AVERAGE(1'b0)) dut_na (
        .clk(clk), .rst_n(rst_n), .y_i(y_i), .cb_i(cb_i), .cr_i(cr_i),
        .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i), .bypass_i(bypass_i),
        .y_o(y_n), .c_o(c_n), .c_sel_o(c_sel_n), .de_o(de_n),
        .hs_o(hs_n), .vs_o(vs_n), .bypass_o(bypass_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] m_avg(input logic [7:0] a, input logic [7:0] b, input bit en);
        int s;
        if (!en) return a;
        s = (int'(a) + int'(b) + 1) / 2;
        return 8'(s);
    endfunction

    // Expected outputs after the latest edge: they describe the sample captured one edge earlier.
    function automatic logic [27:0] exp_bundle(input bit en);
        int k;
        logic [7:0] ey, ec, eb;
        logic es, ed, eh, ev;
        k = edge_cnt - 1;
        ey = 8'd0; ec = 8'd0; eb = 8'd0;
        es = 1'b0; ed = 1'b0; eh = 1'b0; ev = 1'b0;
        if (k >= first_valid) begin
            eh = hs_h[k];
            ev = vs_h[k];
            eb = byp_h[k];
            if (de_h[k]) begin
                ed = 1'b1;
                ey = y_h[k];
                if (run_pos[k] % 2 == 1) begin
                    es = 1'b1;
                    ec = m_avg(cr_h[k-1], cr_h[k], en);
                end else if (de_h[k+1]) begin
                    ec = m_avg(cb_h[k], cb_h[k+1], en);
                end else begin
                    ec = cb_h[k];
                end
            end
        end
        return {ey, ec, es, ed, eh, ev, eb};
    endfunction

    task automatic drive(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr,
                         input logic de, input logic hs, input logic vs, input logic [7:0] byp);
        int idx;
        idx = edge_cnt + 1;
        y_i = y; cb_i = cb; cr_i = cr; de_i = de; hs_i = hs; vs_i = vs; bypass_i = byp;
        y_h[idx] = y; cb_h[idx] = cb; cr_h[idx] = cr; de_h[idx] = de;
        hs_h[idx] = hs; vs_h[idx] = vs; byp_h[idx] = byp;
        if (!de) run_pos[idx] = -1;
        else if (idx - 1 >= first_valid && de_h[idx-1]) run_pos[idx] = run_pos[idx-1] + 1;
        else run_pos[idx] = 0;
        @(posedge clk);
        edge_cnt = idx;
        #1;
    endtask

    task automatic idle();
        drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1, 8'hA5);
            checks++;
            if (got_a !== 28'd0 || got_n !== 28'd0) begin
                errors++;
                $display("[TB] FAIL reset_hold t=%0d got=%h/%h want=0", edge_cnt, got_a, got_n);
            end
        end
        rst_n = 1'b1;
        first_valid = edge_cnt + 1;
        for (int i = 0; i < 2; i++) begin
            idle();
            checks++;
            if (got_a !== exp_bundle(1'b1) || got_n !== exp_bundle(1'b0)) begin
                errors++;
                $display("[TB] FAIL reset_release t=%0d got=%h/%h want=%h/%h",
                         edge_cnt, got_a, got_n, exp_bundle(1'b1), exp_bundle(1'b0));
            end
        end
    endtask

    task automatic test_even_run();
        logic [7:0] cb_v [4] = '{8'd10, 8'd20, 8'd30, 8'd41};
        logic [7:0] cr_v [4] = '{8'd100, 8'd110, 8'd120, 8'd131};
        logic [7:0] want_c [4] = '{8'd15, 8'd105, 8'd36, 8'd126};
        logic       want_s [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [7:0] got_c [$];
        logic       got_s [$];
        for (int i = 0; i < 7; i++) begin
            if (i < 4) drive(8'($urandom_range(1, 255)), cb_v[i], cr_v[i], 1'b1, 1'b0, 1'b0, 8'd0);
            else idle();
            checks++;
            if (got_a !== exp_bundle(1'b1) || got_n !== exp_bundle(1'b0)) begin
                errors++;
                $display("[TB] FAIL even_run_model t=%0d got=%h/%h want=%h/%h",
                         edge_cnt, got_a, got_n, exp_bundle(1'b1), exp_bundle(1'b0));
            end
            if (de_o) begin
                got_c.push_back(c_o);
                got_s.push_back(c_sel_o);
            end
        end
        checks++;
        if (got_c.size() != 4) begin
            errors++;
            $display("[TB] FAIL even_run_len got=%0d want=4", got_c.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_c[i] !== want_c[i] || got_s[i] !== want_s[i]) begin
                    errors++;
                    $display("[TB] FAIL even_run_c[%0d] got=%0d/%0b want=%0d/%0b",
                             i, got_c[i], got_s[i], want_c[i], want_s[i]);
                end
            end
        end
    endtask

    task automatic test_odd_run();
        logic [7:0] cb_v [3] = '{8'd8, 8'd8, 8'd50};
        logic [7:0] cr_v [3] = '{8'd4, 8'd6, 8'd7};
        logic [7:0] want_c [3] = '{8'd8, 8'd5, 8'd50};
        logic       want_s [3] = '{1'b0, 1'b1, 1'b0};
        logic [7:0] got_c [$];
        logic       got_s [$];
        for (int i = 0; i < 6; i++) begin
            if (i < 3) drive(8'($urandom_range(1, 255)), cb_v[i], cr_v[i], 1'b1, 1'b0, 1'b0, 8'd0);
            else idle();
            checks++;
            if (got_a !== exp_bundle(1'b1) || got_n !== exp_bundle(1'b0)) begin
                errors++;
                $display("[TB] FAIL odd_run_model t=%0d got=%h/%h want=%h/%h",
                         edge_cnt, got_a, got_n, exp_bundle(1'b1), exp_bundle(1'b0));
            end
            if (de_o) begin
                got_c.push_back(c_o);
                got_s.push_back(c_sel_o);
            end
        end
        checks++;
        if (got_c.size() != 3) begin
            errors++;
            $display("[TB] FAIL odd_run_de_cycles got=%0d want=3", got_c.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got_c[i] !== want_c[i] || got_s[i] !== want_s[i]) begin
                    errors++;
                    $display("[TB] FAIL odd_run_c[%0d] got=%0d/%0b want=%0d/%0b",
                             i, got_c[i], got_s[i], want_c[i], want_s[i]);
                end
            end
        end
    endtask

    task automatic test_extremes();
        logic [7:0] cb_v [6] = '{8'd255, 8'd255, 8'd0, 8'd1, 8'd10, 8'd20};
        logic [7:0] cr_v [6] = '{8'd255, 8'd255, 8'd0, 8'd0, 8'd40, 8'd60};
        logic [7:0] want_a [6] = '{8'd255, 8'd255, 8'd1, 8'd0, 8'd15, 8'd50};
        logic [7:0] want_n [6] = '{8'd255, 8'd255, 8'd0, 8'd0, 8'd10, 8'd40};
        logic [7:0] got_ca [$];
        logic [7:0] got_cn [$];
        int p;
        p = 0;
        // Three pairs separated by single idle cycles, then a trailing flush.
        for (int i = 0; i < 11; i++) begin
            if (i % 3 != 2 && p < 6) begin
                drive(8'($urandom_range(1, 255)), cb_v[p], cr_v[p], 1'b1, 1'b0, 1'b0, 8'd0);
                p++;
            end else begin
                idle();
            end
            checks++;
            if (got_a !== exp_bundle(1'b1) || got_n !== exp_bundle(1'b0)) begin
                errors++;
                $display("[TB] FAIL extremes_model t=%0d got=%h/%h want=%h/%h",
                         edge_cnt, got_a, got_n, exp_bundle(1'b1), exp_bundle(1'b0));
            end
            if (de_o) got_ca.push_back(c_o);
            if (de_n) got_cn.push_back(c_n);
        end
        checks++;
        if (got_ca.size() != 6 || got_cn.size() != 6) begin
            errors++;
            $display("[TB] FAIL extremes_len got=%0d/%0d want=6", got_ca.size(), got_cn.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (got_ca[i] !== want_a[i] || got_cn[i] !== want_n[i]) begin
                    errors++;
                    $display("[TB] FAIL extremes_c[%0d] got=%0d/%0d want=%0d/%0d",
                             i, got_ca[i], got_cn[i], want_a[i], want_n[i]);
                end
            end
        end
    endtask

    task automatic test_syncs();
        for (int i = 0; i < 60; i++) begin
            drive(8'($urandom), 8'($urandom), 8'($urandom), ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 2) == 0) ? 8'hA5 : 8'h00);
            checks++;
            if (got_a !== exp_bundle(1'b1) || got_n !== exp_bundle(1'b0)) begin
                errors++;
                $display("[TB] FAIL syncs t=%0d got=%h/%h want=%h/%h",
                         edge_cnt, got_a, got_n, exp_bundle(1'b1), exp_bundle(1'b0));
            end
        end
        idle();
        idle();
    endtask

    task automatic test_mid_reset();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 3; i++)
            drive(8'($urandom_range(1, 255)), 8'($urandom), 8'($urandom), 1'b1, 1'b1, 1'b1, 8'hA5);
        // s1 now holds an even pixel whose odd partner has not arrived yet.
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (got_a !== 28'd0 || got_n !== 28'd0) begin
            errors++;
            $display("[TB] FAIL mid_reset_async got=%h/%h want=0", got_a, got_n);
        end
        for (int i = 0; i < 2; i++) begin
            drive(8'($urandom_range(1, 255)), 8'($urandom), 8'($urandom), 1'b1, 1'b1, 1'b0, 8'hA5);
            checks++;
            if (got_a !== 28'd0 || got_n !== 28'd0) begin
                errors++;
                $display("[TB] FAIL mid_reset_hold t=%0d got=%h/%h want=0", edge_cnt, got_a, got_n);
            end
        end
        #2 rst_n = 1'b1;
        first_valid = edge_cnt + 1;
        for (int i = 0; i < 7; i++) begin
            if (i < 5) drive(8'($urandom_range(1, 255)), 8'($urandom), 8'($urandom), 1'b1, 1'b0, 1'b0, 8'd0);
            else idle();
            checks++;
            if (got_a !== exp_bundle(1'b1) || got_n !== exp_bundle(1'b0)) begin
                errors++;
                $display("[TB] FAIL mid_reset_model t=%0d got=%h/%h want=%h/%h",
                         edge_cnt, got_a, got_n, exp_bundle(1'b1), exp_bundle(1'b0));
            end
            if (de_o && !seen) begin
                seen = 1'b1;
                checks++;
                if (c_sel_o !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL mid_reset_first_sel got=%0b want=0", c_sel_o);
                end
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL mid_reset_no_output got=0 pixels want=5");
        end
    endtask

    task automatic test_split_run();
        logic de_pat [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic want_s [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic got_s [$];
        for (int i = 0; i < 8; i++) begin
            drive(8'($urandom), 8'($urandom), 8'($urandom), de_pat[i], 1'b0, 1'b0, 8'd0);
            checks++;
            if (got_a !== exp_bundle(1'b1) || got_n !== exp_bundle(1'b0)) begin
                errors++;
                $display("[TB] FAIL split_model t=%0d got=%h/%h want=%h/%h",
                         edge_cnt, got_a, got_n, exp_bundle(1'b1), exp_bundle(1'b0));
            end
            if (de_o) got_s.push_back(c_sel_o);
        end
        checks++;
        if (got_s.size() != 5) begin
            errors++;
            $display("[TB] FAIL split_len got=%0d want=5", got_s.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (got_s[i] !== want_s[i]) begin
                    errors++;
                    $display("[TB] FAIL split_sel[%0d] got=%0b want=%0b", i, got_s[i], want_s[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(8'($urandom), 8'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 29) == 0), 8'($urandom));
            checks++;
            if (got_a !== exp_bundle(1'b1) || got_n !== exp_bundle(1'b0)) begin
                errors++;
                $display("[TB] FAIL random t=%0d got=%h/%h want=%h/%h",
                         edge_cnt, got_a, got_n, exp_bundle(1'b1), exp_bundle(1'b0));
            end
        end
        idle();
        idle();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout t=%0t got=running want=finished", $time);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_n = 1'b0;
        y_i = 8'd0; cb_i = 8'd0; cr_i = 8'd0; bypass_i = 8'd0;
        de_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
        #2;
        test_reset();
        test_even_run();
        test_odd_run();
        test_extremes();
        test_syncs();
        test_mid_reset();
        test_split_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
